axi_mux8_pkt: RTL and testbench
===============================

# axi_mux8_pkt

Packet-level 8-to-1 AXI-Stream multiplexer: merges up to eight input streams onto one output without interleaving packets. It is the return-path counterpart of the 1-to-8 packet demux, e.g. collecting per-channel responses back onto a single crossbar or host link. Arbitration is round-robin or fixed-priority and is decided once per packet. The grant is held until the output accepts the beat carrying `tlast`.

## Interface
- `ACTIVE_CHAN`, 8'hFF: per-input enable mask. Masked inputs never win a grant and their `tready` is tied 0.
- `WIDTH`, 64: tdata width in bits.
- `PRIO`, 0: 0 selects round-robin; 1 selects fixed priority, lowest index wins.
- `BUFFER`, 0: 1 inserts a 2-entry skid register on the output.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush, active-high.
- `iN_tdata` / `iN_tlast` / `iN_tvalid`  in  WIDTH/1/1  input channel N, for N=0..7.
- `iN_tready`  out  1  ready for input channel N.
- `o_tdata` / `o_tlast` / `o_tvalid`  out  WIDTH/1/1  merged output stream.
- `o_tready`  in  1  output ready.
- `src`  out  3  index of the currently or most recently granted input.
- `busy`  out  1  high while a packet grant is held.

## Operation
- FSM states:
  - IDLE: no grant held; arbitrate.
  - ACTIVE: pass the granted channel through.
- IDLE:
  - All `iN_tready` are 0.
  - If any unmasked `iN_tvalid` is high, register the winner into `src`, set `busy`, and go to ACTIVE.
  - If no unmasked input is valid, stay in IDLE.
- Round-robin:
  - Search starts at `last+1` and wraps 7→0.
  - `last` resets to 7, so input 0 has highest priority first.
  - `last` updates to the winner at grant time.
- Fixed priority: the lowest-index valid unmasked input wins. `last` is ignored.
- ACTIVE:
  - `o_*` are driven from input `src`.
  - `i[src]_tready` follows downstream ready; every other `tready` is 0.
  - The FSM stays in ACTIVE across `tvalid` gaps mid-packet.
- End of packet:
  - The handshake on input `src` with `tlast`=1 moves the FSM to IDLE and clears `busy`.
  - `src` holds its value until the next grant.
- Single-beat packets (`tlast` on the first beat) are legal: grant, one transfer, back to IDLE.
- `clear`:
  - Forces IDLE, empties the skid buffer, and resets `last` to 7.
  - A packet in flight is truncated; the remainder of that packet arrives later as a new packet.
  - `clear` has priority over a simultaneous `tlast` handshake.
- Reset mid-operation has the same effect as `clear`, but is asynchronous.
- Reset values:
  - `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0.
  - All `iN_tready`=0.
  - `src`=0, `busy`=0, state IDLE.

## Timing
- Arbitration costs one bubble cycle per packet: valid seen in cycle t, grant registered at the edge, first transfer possible in cycle t+1.
- BUFFER=0:
  - `o_*` are combinational from the selected input.
  - `i[src]_tready` = `o_tready` AND state==ACTIVE.
  - Zero data latency.
- BUFFER=1:
  - Output is registered, adding 1 cycle of latency.
  - No combinational path from `o_tready` to any `iN_tready`.
  - Full throughput is sustained: 1 beat per cycle while `o_tready` is held high.
  - The skid buffer must drain before `busy` clears. The FSM may re-arbitrate while the tail beat is still in the buffer.
- Packets are separated by a minimum of one idle cycle on the input side. Back-to-back grants to the same input are allowed.

## Configuration
- `AXI_MUX8_PKT_STATS_EN`:
  - When defined, adds output `pkt_count[31:0]`: a count of completed output packets (`o_tlast` handshakes). It wraps at 2^32 and is zeroed by `reset` and `clear`.
  - Without the macro, the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package `axi_mux8_pkt_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_ACTIVE`).
  - `NUM_CH`=8.
  - `SRC_W`=3.
- Sub-module `axi_mux8_rr_arb`: combinational 8-way round-robin/priority selector. Inputs are the request vector, `last`, and `PRIO`; outputs are the winner index and a valid flag.
- The skid stage reuses the existing 2-entry AXI flop FIFO when BUFFER=1.

## Test plan
- Reset, then i3 sends a 4-beat packet with tdata 0x30..0x33 and `o_tready`=1 → `o_tdata` carries 0x30..0x33 in order, `o_tlast` only on 0x33, `src`=3, `busy` drops the cycle after the tlast handshake.
- i0, i2 and i7 all valid simultaneously with 2-beat packets, PRIO=0 → output order is 0, 2, 7; the next round, with all three still requesting, starts at 0.
- Same stimulus with PRIO=1 and i0 re-requesting continuously → i0 is served repeatedly and i2/i7 never win.
- ACTIVE_CHAN=8'h0F, i5 valid → `i5_tready` stays 0, `o_tvalid` stays 0, state remains IDLE.
- Mid-packet on i1 (beat 2 of 5), `o_tready` toggles 1010… → no data loss or duplication; `clear` pulsed at beat 3 → IDLE next cycle and `o_tvalid`=0 (BUFFER=1: skid emptied).
- With STATS_EN defined: 10 packets across random inputs under random `o_tready` → `pkt_count`=10; `reset` asserted low mid-packet → `pkt_count`=0 and all `tready`=0 immediately.

Source files
------------

// File: rtl/axi_mux8_pkt_pkg.sv
// Shared types and constants for the packet-level 8-to-1 AXI-Stream mux.
package axi_mux8_pkt_pkg;
   localparam int NUM_CH = 8;
   localparam int SRC_W  = 3;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;
endpackage

// File: rtl/axi_mux8_pkt_rr_arb.sv
// Combinational 8-way selector: round-robin starting after last_i, or fixed
// priority (lowest index wins) when PRIO != 0.
module axi_mux8_rr_arb
   import axi_mux8_pkt_pkg::*;
#(
   parameter int PRIO = 0
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [SRC_W-1:0]  last_i,
   output logic [SRC_W-1:0]  win_o,
   output logic              win_vld_o
);

   logic [SRC_W-1:0] idx;

   always_comb begin
      win_o     = '0;
      win_vld_o = |req_i;
      idx       = '0;
      if (PRIO != 0) begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_i[k]) win_o = SRC_W'(k);
         end
      end else begin
         // Walk from farthest to nearest so the first requester after last_i wins.
         for (int k = NUM_CH; k >= 1; k--) begin
            idx = last_i + SRC_W'(k);
            if (req_i[idx]) win_o = idx;
         end
      end
   end

endmodule

// File: rtl/axi_mux8_pkt.sv
// Packet-level 8-to-1 AXI-Stream mux; grant is held until the tlast beat is accepted.
// Optional macro AXI_MUX8_PKT_STATS_EN adds the pkt_count output packet counter.
module axi_mux8_pkt
   import axi_mux8_pkt_pkg::*;
#(
   parameter logic [NUM_CH-1:0] ACTIVE_CHAN = 8'hFF,
   parameter int                WIDTH       = 64,
   parameter int                PRIO        = 0,
   parameter int                BUFFER      = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] i0_tdata,
   input  logic             i0_tlast,
   input  logic             i0_tvalid,
   output logic             i0_tready,
   input  logic [WIDTH-1:0] i1_tdata,
   input  logic             i1_tlast,
   input  logic             i1_tvalid,
   output logic             i1_tready,
   input  logic [WIDTH-1:0] i2_tdata,
   input  logic             i2_tlast,
   input  logic             i2_tvalid,
   output logic             i2_tready,
   input  logic [WIDTH-1:0] i3_tdata,
   input  logic             i3_tlast,
   input  logic             i3_tvalid,
   output logic             i3_tready,
   input  logic [WIDTH-1:0] i4_tdata,
   input  logic             i4_tlast,
   input  logic             i4_tvalid,
   output logic             i4_tready,
   input  logic [WIDTH-1:0] i5_tdata,
   input  logic             i5_tlast,
   input  logic             i5_tvalid,
   output logic             i5_tready,
   input  logic [WIDTH-1:0] i6_tdata,
   input  logic             i6_tlast,
   input  logic             i6_tvalid,
   output logic             i6_tready,
   input  logic [WIDTH-1:0] i7_tdata,
   input  logic             i7_tlast,
   input  logic             i7_tvalid,
   output logic             i7_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [SRC_W-1:0] src,
   output logic             busy
`ifdef AXI_MUX8_PKT_STATS_EN
   ,
   output logic [31:0]      pkt_count
`endif
);

   // Handshake rule: a beat moves when tvalid && tready are both high at a rising
   // clk edge; a source holds tvalid and its data steady until that edge.

   logic [NUM_CH-1:0][WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]            in_last, in_vld, in_rdy, req;

   assign in_data = {i7_tdata, i6_tdata, i5_tdata, i4_tdata,
                     i3_tdata, i2_tdata, i1_tdata, i0_tdata};
   assign in_last = {i7_tlast, i6_tlast, i5_tlast, i4_tlast,
                     i3_tlast, i2_tlast, i1_tlast, i0_tlast};
   assign in_vld  = {i7_tvalid, i6_tvalid, i5_tvalid, i4_tvalid,
                     i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid};
   assign {i7_tready, i6_tready, i5_tready, i4_tready,
           i3_tready, i2_tready, i1_tready, i0_tready} = in_rdy;

   state_e           state_q, state_d;
   logic [SRC_W-1:0] src_q, src_d, last_q, last_d;
   logic [SRC_W-1:0] win;
   logic             win_vld;
   logic             active, up_rdy, in_hs, buf_busy;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last, sel_vld;

   assign req = in_vld & ACTIVE_CHAN;

   axi_mux8_rr_arb #(.PRIO(PRIO)) u_arb (
      .req_i     (req),
      .last_i    (last_q),
      .win_o     (win),
      .win_vld_o (win_vld)
   );

   assign active   = (state_q == ST_ACTIVE);
   assign sel_data = in_data[src_q];
   assign sel_last = in_last[src_q];
   assign sel_vld  = in_vld[src_q];
   assign in_hs    = active && sel_vld && up_rdy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         last_q  <= '1;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         last_q  <= last_d;
      end
   end

   // clear outranks a concurrent tlast handshake and rewinds the RR pointer.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      last_d  = last_q;
      if (clear) begin
         state_d = ST_IDLE;
         last_d  = '1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win_vld) begin
                  state_d = ST_ACTIVE;
                  src_d   = win;
                  last_d  = win;
               end
            end
            ST_ACTIVE: begin
               if (in_hs && sel_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_rdy = '0;
      if (active) in_rdy[src_q] = up_rdy & ACTIVE_CHAN[src_q];
   end

   generate
      if (BUFFER != 0) begin : g_skid
         logic [WIDTH:0] mem_q [2];
         logic           wr_q, rd_q;
         logic [1:0]     cnt_q, cnt_d;
         logic           push, pop;

         assign push = in_hs;
         assign pop  = (cnt_q != 2'd0) && o_tready;

         always_comb begin
            cnt_d = cnt_q;
            case ({push, pop})
               2'b10:   cnt_d = cnt_q + 2'd1;
               2'b01:   cnt_d = cnt_q - 2'd1;
               default: cnt_d = cnt_q;
            endcase
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               mem_q[0] <= '0;
               mem_q[1] <= '0;
               wr_q     <= 1'b0;
               rd_q     <= 1'b0;
               cnt_q    <= 2'd0;
            end else if (clear) begin
               wr_q  <= 1'b0;
               rd_q  <= 1'b0;
               cnt_q <= 2'd0;
            end else begin
               if (push) begin
                  mem_q[wr_q] <= {sel_last, sel_data};
                  wr_q        <= ~wr_q;
               end
               if (pop) rd_q <= ~rd_q;
               cnt_q <= cnt_d;
            end
         end

         // Upstream ready depends only on occupancy, never on o_tready.
         assign up_rdy              = (cnt_q != 2'd2);
         assign o_tvalid            = (cnt_q != 2'd0);
         assign {o_tlast, o_tdata}  = mem_q[rd_q];
         assign buf_busy            = o_tvalid;
      end else begin : g_pass
         assign up_rdy   = o_tready;
         assign o_tvalid = active & sel_vld;
         assign o_tlast  = active & sel_last;
         assign o_tdata  = active ? sel_data : '0;
         assign buf_busy = 1'b0;
      end
   endgenerate

   assign src  = src_q;
   assign busy = active | buf_busy;

`ifdef AXI_MUX8_PKT_STATS_EN
   logic [31:0] pkt_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             pkt_cnt_q <= '0;
      else if (clear)                         pkt_cnt_q <= '0;
      else if (o_tvalid && o_tready && o_tlast) pkt_cnt_q <= pkt_cnt_q + 32'd1;
   end

   assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axi_mux8_pkt.sv
// Directed bench for axi_mux8_pkt: three instances (RR unbuffered, PRIO buffered,
// masked 8'h0F) share one set of sources; sel chooses whose tready the sources obey.
module tb_axi_mux8_pkt;
   localparam int W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, clear, o_tready;
   logic [W-1:0] in_data  [8];
   logic         in_last  [8];
   logic         in_valid [8];

   wire [7:0]   rdy     [3];
   wire [W-1:0] o_data  [3];
   wire         o_last  [3];
   wire         o_valid [3];
   wire [2:0]   srcw    [3];
   wire         busyw   [3];
`ifdef AXI_MUX8_PKT_STATS_EN
   wire [31:0]  pcnt    [3];
`endif

   int           sel;
   logic         toggle, rnd;
   logic [W:0]   bq [8][$];
   logic [W:0]   obs_q [$];
   logic [W:0]   exp_q [$];
   int           errors = 0;
   int           checks = 0;

   axi_mux8_pkt #(.ACTIVE_CHAN(8'hFF), .WIDTH(W), .PRIO(0), .BUFFER(0)) u0 (
      .clk(clk), .reset(reset), .clear(clear),
      .i0_tdata(in_data[0]), .i0_tlast(in_last[0]), .i0_tvalid(in_valid[0]), .i0_tready(rdy[0][0]),
      .i1_tdata(in_data[1]), .i1_tlast(in_last[1]), .i1_tvalid(in_valid[1]), .i1_tready(rdy[0][1]),
      .i2_tdata(in_data[2]), .i2_tlast(in_last[2]), .i2_tvalid(in_valid[2]), .i2_tready(rdy[0][2]),
      .i3_tdata(in_data[3]), .i3_tlast(in_last[3]), .i3_tvalid(in_valid[3]), .i3_tready(rdy[0][3]),
      .i4_tdata(in_data[4]), .i4_tlast(in_last[4]), .i4_tvalid(in_valid[4]), .i4_tready(rdy[0][4]),
      .i5_tdata(in_data[5]), .i5_tlast(in_last[5]), .i5_tvalid(in_valid[5]), .i5_tready(rdy[0][5]),
      .i6_tdata(in_data[6]), .i6_tlast(in_last[6]), .i6_tvalid(in_valid[6]), .i6_tready(rdy[0][6]),
      .i7_tdata(in_data[7]), .i7_tlast(in_last[7]), .i7_tvalid(in_valid[7]), .i7_tready(rdy[0][7]),
      .o_tdata(o_data[0]), .o_tlast(o_last[0]), .o_tvalid(o_valid[0]), .o_tready(o_tready),
      .src(srcw[0]), .busy(busyw[0])
`ifdef AXI_MUX8_PKT_STATS_EN
      , .pkt_count(pcnt[0])
`endif
   );

   axi_mux8_pkt #(.ACTIVE_CHAN(8'hFF), .WIDTH(W), .PRIO(1), .BUFFER(1)) u1 (
      .clk(clk), .reset(reset), .clear(clear),
      .i0_tdata(in_data[0]), .i0_tlast(in_last[0]), .i0_tvalid(in_valid[0]), .i0_tready(rdy[1][0]),
      .i1_tdata(in_data[1]), .i1_tlast(in_last[1]), .i1_tvalid(in_valid[1]), .i1_tready(rdy[1][1]),
      .i2_tdata(in_data[2]), .i2_tlast(in_last[2]), .i2_tvalid(in_valid[2]), .i2_tready(rdy[1][2]),
      .i3_tdata(in_data[3]), .i3_tlast(in_last[3]), .i3_tvalid(in_valid[3]), .i3_tready(rdy[1][3]),
      .i4_tdata(in_data[4]), .i4_tlast(in_last[4]), .i4_tvalid(in_valid[4]), .i4_tready(rdy[1][4]),
      .i5_tdata(in_data[5]), .i5_tlast(in_last[5]), .i5_tvalid(in_valid[5]), .i5_tready(rdy[1][5]),
      .i6_tdata(in_data[6]), .i6_tlast(in_last[6]), .i6_tvalid(in_valid[6]), .i6_tready(rdy[1][6]),
      .i7_tdata(in_data[7]), .i7_tlast(in_last[7]), .i7_tvalid(in_valid[7]), .i7_tready(rdy[1][7]),
      .o_tdata(o_data[1]), .o_tlast(o_last[1]), .o_tvalid(o_valid[1]), .o_tready(o_tready),
      .src(srcw[1]), .busy(busyw[1])
`ifdef AXI_MUX8_PKT_STATS_EN
      , .pkt_count(pcnt[1])
`endif
   );

   axi_mux8_pkt #(.ACTIVE_CHAN(8'h0F), .WIDTH(W), .PRIO(0), .BUFFER(0)) u2 (
      .clk(clk), .reset(reset), .clear(clear),
      .i0_tdata(in_data[0]), .i0_tlast(in_last[0]), .i0_tvalid(in_valid[0]), .i0_tready(rdy[2][0]),
      .i1_tdata(in_data[1]), .i1_tlast(in_last[1]), .i1_tvalid(in_valid[1]), .i1_tready(rdy[2][1]),
      .i2_tdata(in_data[2]), .i2_tlast(in_last[2]), .i2_tvalid(in_valid[2]), .i2_tready(rdy[2][2]),
      .i3_tdata(in_data[3]), .i3_tlast(in_last[3]), .i3_tvalid(in_valid[3]), .i3_tready(rdy[2][3]),
      .i4_tdata(in_data[4]), .i4_tlast(in_last[4]), .i4_tvalid(in_valid[4]), .i4_tready(rdy[2][4]),
      .i5_tdata(in_data[5]), .i5_tlast(in_last[5]), .i5_tvalid(in_valid[5]), .i5_tready(rdy[2][5]),
      .i6_tdata(in_data[6]), .i6_tlast(in_last[6]), .i6_tvalid(in_valid[6]), .i6_tready(rdy[2][6]),
      .i7_tdata(in_data[7]), .i7_tlast(in_last[7]), .i7_tvalid(in_valid[7]), .i7_tready(rdy[2][7]),
      .o_tdata(o_data[2]), .o_tlast(o_last[2]), .o_tvalid(o_valid[2]), .o_tready(o_tready),
      .src(srcw[2]), .busy(busyw[2])
`ifdef AXI_MUX8_PKT_STATS_EN
      , .pkt_count(pcnt[2])
`endif
   );

   // ---------------- driver tasks ----------------
   task automatic present();
      for (int c = 0; c < 8; c++) begin
         in_valid[c] = (bq[c].size() != 0);
         if (bq[c].size() != 0) {in_last[c], in_data[c]} = bq[c][0];
         else begin
            in_last[c] = 1'b0;
            in_data[c] = '0;
         end
      end
      if (toggle) o_tready = ~o_tready;
      else if (rnd) o_tready = 1'($urandom_range(0, 1));
   endtask

   // One clock: sample handshakes mid-cycle, retire accepted beats after the edge.
   task automatic cycle();
      logic [7:0] hs;
      @(negedge clk);
      for (int c = 0; c < 8; c++) hs[c] = in_valid[c] && rdy[sel][c];
      if (o_valid[sel] && o_tready) obs_q.push_back({o_last[sel], o_data[sel]});
      @(posedge clk);
      #1;
      if (reset) begin
         for (int c = 0; c < 8; c++) if (hs[c]) void'(bq[c].pop_front());
      end
      present();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int c = 0; c < 8; c++) if (bq[c].size() != 0) p = 1'b1;
      return p;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; clear = 1'b0; o_tready = 1'b0; toggle = 1'b0; rnd = 1'b0; sel = 0;
      for (int c = 0; c < 8; c++) bq[c].delete();
      present();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({o_valid[k], o_last[k], busyw[k], srcw[k], rdy[k]} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl dut%0d: valid=%b last=%b busy=%b src=%0d rdy=%h, expected all 0",
                     k, o_valid[k], o_last[k], busyw[k], srcw[k], rdy[k]);
         end
         checks++;
         if (o_data[k] !== '0) begin
            errors++;
            $display("FAIL reset_data dut%0d: got %h expected 0", k, o_data[k]);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_single_packet();
      int n;
      logic [W:0] got, exp;
      sel = 0; do_clear(); obs_q.delete(); o_tready = 1'b1;
      for (int b = 0; b < 4; b++) bq[3].push_back({b == 3, W'(48 + b)});
      present();
      cycle(); n = 1;
      checks++;
      if (busyw[0] !== 1'b1 || srcw[0] !== 3'd3) begin
         errors++;
         $display("FAIL single_grant: busy=%b src=%0d expected busy=1 src=3", busyw[0], srcw[0]);
      end
      while (obs_q.size() < 4 && n < 20) begin cycle(); n++; end
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL single_latency: took %0d cycles expected 5", n);
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         exp = {i == 3, W'(48 + i)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL single_beat%0d: got %h expected %h", i, got, exp);
         end
      end
      checks++;
      if (busyw[0] !== 1'b0 || srcw[0] !== 3'd3) begin
         errors++;
         $display("FAIL single_end: busy=%b src=%0d expected busy=0 src=3", busyw[0], srcw[0]);
      end
   endtask

   task automatic run_order(input int dut, input string name, input int limit);
      int n = 0;
      logic [W:0] got;
      present();
      while (obs_q.size() < exp_q.size() && n < limit) begin cycle(); n++; end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d beats expected %0d", name, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL %s_beat%0d dut%0d: got %h expected %h", name, i, dut, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_round_robin();
      int chs [3] = '{0, 2, 7};
      logic [W:0] beat;
      sel = 0; do_clear(); obs_q.delete(); exp_q.delete(); o_tready = 1'b1;
      for (int p = 0; p < 2; p++)
         for (int j = 0; j < 3; j++)
            for (int b = 0; b < 2; b++) begin
               beat = {b == 1, W'(chs[j] * 256 + p * 16 + b)};
               bq[chs[j]].push_back(beat);
               exp_q.push_back(beat);   // RR order: 0, 2, 7, then 0 again
            end
      run_order(0, "rr", 60);
   endtask

   task automatic test_fixed_prio();
      logic [W:0] beat;
      sel = 1; do_clear(); obs_q.delete(); exp_q.delete(); o_tready = 1'b1;
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 2; b++) begin
            beat = {b == 1, W'(p * 16 + b)};
            bq[0].push_back(beat); exp_q.push_back(beat);
         end
      for (int b = 0; b < 2; b++) begin
         beat = {b == 1, W'(16'h0200 + b)};
         bq[2].push_back(beat); exp_q.push_back(beat);
      end
      for (int b = 0; b < 2; b++) begin
         beat = {b == 1, W'(16'h0700 + b)};
         bq[7].push_back(beat); exp_q.push_back(beat);
      end
      run_order(1, "prio", 100);
      checks++;
      if (srcw[1] !== 3'd7) begin
         errors++;
         $display("FAIL prio_src: got %0d expected 7", srcw[1]);
      end
   endtask

   task automatic test_buffer_throughput();
      int n = 0;
      sel = 1; do_clear(); obs_q.delete(); exp_q.delete(); o_tready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         bq[4].push_back({b == 7, W'(16'h0400 + b)});
         exp_q.push_back({b == 7, W'(16'h0400 + b)});
      end
      present();
      while (obs_q.size() < 8 && n < 30) begin cycle(); n++; end
      checks++;
      if (n !== 10) begin
         errors++;
         $display("FAIL buf_latency: took %0d cycles expected 10", n);
      end
      checks++;
      if (busyw[1] !== 1'b0 || o_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL buf_drain: busy=%b valid=%b expected 0 0", busyw[1], o_valid[1]);
      end
      run_order(1, "buf", 5);
   endtask

   task automatic test_mask();
      int n = 0;
      sel = 2; do_clear(); obs_q.delete(); o_tready = 1'b1;
      bq[5].push_back({1'b1, W'(16'h0055)});
      present();
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (rdy[2][5] !== 1'b0) begin
            errors++; $display("FAIL mask_rdy%0d: got %b expected 0", i, rdy[2][5]);
         end
         checks++;
         if (o_valid[2] !== 1'b0) begin
            errors++; $display("FAIL mask_valid%0d: got %b expected 0", i, o_valid[2]);
         end
         checks++;
         if (busyw[2] !== 1'b0) begin
            errors++; $display("FAIL mask_busy%0d: got %b expected 0", i, busyw[2]);
         end
      end
      bq[5].delete();
      bq[1].push_back({1'b1, W'(16'h0011)});
      present();
      while (obs_q.size() < 1 && n < 10) begin cycle(); n++; end
      checks++;
      if (obs_q.size() !== 1 || obs_q[0] !== {1'b1, W'(16'h0011)}) begin
         errors++;
         $display("FAIL mask_unmasked: got %0d beats expected 1 beat of 0x11", obs_q.size());
      end
   endtask

   task automatic test_clear_midpacket();
      int n = 0;
      logic [W:0] got, exp;
      sel = 0; do_clear(); obs_q.delete();
      for (int b = 0; b < 5; b++) bq[1].push_back({b == 4, W'(16 + b)});
      o_tready = 1'b0; toggle = 1'b1;
      present();
      while (obs_q.size() < 3 && n < 30) begin cycle(); n++; end
      toggle = 1'b0; o_tready = 1'b0; clear = 1'b1;
      cycle();
      clear = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busyw[k] !== 1'b0 || o_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle dut%0d: busy=%b valid=%b expected 0 0", k, busyw[k], o_valid[k]);
         end
         checks++;
         if (rdy[k] !== 8'h00) begin
            errors++;
            $display("FAIL clear_rdy dut%0d: got %h expected 00", k, rdy[k]);
         end
      end
      toggle = 1'b1; n = 0;
      while (obs_q.size() < 5 && n < 40) begin cycle(); n++; end
      toggle = 1'b0; o_tready = 1'b1;
      checks++;
      if (obs_q.size() !== 5 || pending()) begin
         errors++;
         $display("FAIL clear_count: got %0d beats expected 5", obs_q.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < obs_q.size()) ? obs_q[i] : 'x;
         exp = {i == 4, W'(16 + i)};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL clear_beat%0d: got %h expected %h", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_midpacket();
      sel = 0; do_clear(); obs_q.delete();
`ifdef AXI_MUX8_PKT_STATS_EN
      begin
         int n = 0;
         for (int p = 0; p < 10; p++) begin
            int ch  = $urandom_range(0, 7);
            int len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) bq[ch].push_back({b == len - 1, W'(p * 16 + b)});
         end
         rnd = 1'b1;
         present();
         while ((pending() || busyw[0]) && n < 500) begin cycle(); n++; end
         rnd = 1'b0;
         checks++;
         if (pcnt[0] !== 32'd10) begin
            errors++;
            $display("FAIL stats_count: got %0d expected 10", pcnt[0]);
         end
      end
`endif
      o_tready = 1'b1;
      for (int b = 0; b < 4; b++) bq[6].push_back({b == 3, W'(16'h0600 + b)});
      present();
      repeat (3) cycle();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdy[k] !== 8'h00 || busyw[k] !== 1'b0 || o_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid dut%0d: rdy=%h busy=%b valid=%b expected 00 0 0",
                     k, rdy[k], busyw[k], o_valid[k]);
         end
`ifdef AXI_MUX8_PKT_STATS_EN
         checks++;
         if (pcnt[k] !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_count dut%0d: got %0d expected 0", k, pcnt[k]);
         end
`endif
      end
      for (int c = 0; c < 8; c++) bq[c].delete();
      present();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_fixed_prio();
      test_buffer_throughput();
      test_mask();
      test_clear_midpacket();
      test_reset_midpacket();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
